// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core: operator codes, FSM states
// and the default datapath width.
package calc_pkg;

    localparam int CALC_WIDTH = 32;

    typedef logic [4:0] op_code_t;

    localparam op_code_t OP_NONE = 5'd0;
    localparam op_code_t OP_ADD  = 5'd1;
    localparam op_code_t OP_SUB  = 5'd2;
    localparam op_code_t OP_MUL  = 5'd3;
    localparam op_code_t OP_DIV  = 5'd4;
    localparam op_code_t OP_EQ   = 5'd5;
    localparam op_code_t OP_AC   = 5'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HAVE_A,
        ST_HAVE_OP,
        ST_HAVE_B,
        ST_EXEC,
        ST_DIV_RUN,
        ST_ERROR
    } state_t;

    function automatic logic is_arith(input op_code_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle. The quotient and
// done are presented combinationally during the final iteration.
module calc_div_seq
    import calc_pkg::*;
#(
    parameter int WIDTH    = CALC_WIDTH,
    parameter int DIV_ITER = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             dz
);

    localparam int CW = $clog2(DIV_ITER + 1);

    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dsr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             dz_reg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    // The true difference is below the divisor, so the low WIDTH bits suffice.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        rem_sub  = shifted[WIDTH-1:0] - dsr_reg;
        fits     = (shifted >= {1'b0, dsr_reg});
        rem_next = fits ? rem_sub : shifted[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_reg <= '0;
            quo_reg <= '0;
            dsr_reg <= '0;
            cnt_reg <= '0;
            dz_reg  <= 1'b0;
        end else if (start) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            dsr_reg <= divisor;
            cnt_reg <= CW'(DIV_ITER);
            dz_reg  <= (divisor == '0);
        end else if (cnt_reg != '0) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign quotient = quo_next;
    assign done     = (cnt_reg == CW'(1));
    assign dz       = dz_reg;

endmodule

// File: rtl/calc_core.sv
// Accumulator calculator: sequences A op B op ... = from keypad strobes,
// evaluates left to right and reports results to the display stage.
module calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH    = CALC_WIDTH,
    parameter int DIV_ITER = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand_in,
    input  logic             operand_valid,
    input  logic [4:0]       op_in,
    input  logic             op_valid,
    input  logic             overflow_in,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             error
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    op_code_t         pend_reg, pend_next;
    op_code_t         nxt_op_reg, nxt_op_next;
    logic             rv_reg, rv_next;
    logic             err_reg, err_next;
    logic             neg_reg, neg_next;

    logic             ac_hit, opnd_hit, opnd_ovf, op_hit;
    logic             div_start, div_done, div_dz;
    logic [WIDTH-1:0] div_q, quo_signed, a_mag, b_mag;
    logic [WIDTH-1:0] sum, diff;
    logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic             add_ovf, sub_ovf, mul_ovf, div_ovf;
    logic             fault, wb, wb_ovf;
    logic [WIDTH-1:0] wb_val;

    // A coinciding operand wins over any non-AC operator.
    assign ac_hit   = op_valid && !overflow_in && (op_in == OP_AC);
    assign opnd_hit = operand_valid && !overflow_in;
    assign opnd_ovf = operand_valid && overflow_in;
    assign op_hit   = op_valid && !overflow_in && !operand_valid;

    assign sum     = acc_reg + b_reg;
    assign diff    = acc_reg - b_reg;
    assign add_ovf = (acc_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != acc_reg[WIDTH-1]);
    assign sub_ovf = (acc_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != acc_reg[WIDTH-1]);

    assign a_ext   = {{WIDTH{acc_reg[WIDTH-1]}}, acc_reg};
    assign b_ext   = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
    assign prod    = a_ext * b_ext;
    assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

    assign a_mag = acc_reg[WIDTH-1] ? -acc_reg : acc_reg;
    assign b_mag = b_reg[WIDTH-1] ? -b_reg : b_reg;

    // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
    assign quo_signed = neg_reg ? -div_q : div_q;
    assign div_ovf    = !neg_reg && div_q[WIDTH-1];

    calc_div_seq #(
        .WIDTH   (WIDTH),
        .DIV_ITER(DIV_ITER)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(a_mag),
        .divisor (b_mag),
        .quotient(div_q),
        .done    (div_done),
        .dz      (div_dz)
    );

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        b_next      = b_reg;
        pend_next   = pend_reg;
        nxt_op_next = nxt_op_reg;
        result_next = result_reg;
        rv_next     = 1'b0;
        err_next    = err_reg;
        neg_next    = neg_reg;
        div_start   = 1'b0;
        fault       = 1'b0;
        wb          = 1'b0;
        wb_ovf      = 1'b0;
        wb_val      = '0;
        if (ac_hit) begin
            state_next  = ST_IDLE;
            acc_next    = '0;
            b_next      = '0;
            pend_next   = OP_NONE;
            result_next = '0;
            rv_next     = 1'b1;
            err_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HAVE_A: begin
                    if (opnd_ovf) begin
                        fault = 1'b1;
                    end else if (opnd_hit) begin
                        acc_next   = operand_in;
                        state_next = ST_HAVE_A;
                    end else if (op_hit && is_arith(op_in)) begin
                        pend_next  = op_in;
                        state_next = ST_HAVE_OP;
                    end else if (op_hit && (op_in == OP_EQ)) begin
                        result_next = acc_reg;
                        rv_next     = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end
                ST_HAVE_OP: begin
                    if (opnd_ovf) begin
                        fault = 1'b1;
                    end else if (opnd_hit) begin
                        b_next     = operand_in;
                        state_next = ST_HAVE_B;
                    end else if (op_hit && is_arith(op_in)) begin
                        pend_next = op_in;
                    end
                end
                ST_HAVE_B: begin
                    if (opnd_ovf) begin
                        fault = 1'b1;
                    end else if (opnd_hit) begin
                        b_next = operand_in;
                    end else if (op_hit && (is_arith(op_in) || (op_in == OP_EQ))) begin
                        nxt_op_next = op_in;
                        state_next  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (pend_reg == OP_DIV) begin
                        div_start  = 1'b1;
                        neg_next   = acc_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                        state_next = ST_DIV_RUN;
                    end else begin
                        wb = 1'b1;
                        case (pend_reg)
                            OP_ADD:  begin wb_val = sum;            wb_ovf = add_ovf; end
                            OP_SUB:  begin wb_val = diff;           wb_ovf = sub_ovf; end
                            default: begin wb_val = prod[WIDTH-1:0]; wb_ovf = mul_ovf; end
                        endcase
                    end
                end
                ST_DIV_RUN: begin
                    if (div_done) begin
                        wb     = 1'b1;
                        wb_val = quo_signed;
                        wb_ovf = div_dz || div_ovf;
                    end
                end
                ST_ERROR: ;
                default: state_next = ST_IDLE;
            endcase

            if (fault || (wb && wb_ovf)) begin
                err_next    = 1'b1;
                result_next = '0;
                rv_next     = 1'b1;
                state_next  = ST_ERROR;
            end else if (wb) begin
                acc_next    = wb_val;
                result_next = wb_val;
                rv_next     = 1'b1;
                if (nxt_op_reg == OP_EQ) begin
                    state_next = ST_IDLE;
                end else begin
                    pend_next  = nxt_op_reg;
                    state_next = ST_HAVE_OP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            b_reg      <= '0;
            pend_reg   <= OP_NONE;
            nxt_op_reg <= OP_NONE;
            result_reg <= '0;
            rv_reg     <= 1'b0;
            err_reg    <= 1'b0;
            neg_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            b_reg      <= b_next;
            pend_reg   <= pend_next;
            nxt_op_reg <= nxt_op_next;
            result_reg <= result_next;
            rv_reg     <= rv_next;
            err_reg    <= err_next;
            neg_reg    <= neg_next;
        end
    end

    assign result       = result_reg;
    assign result_valid = rv_reg;
    assign busy         = (state_reg == ST_EXEC) || (state_reg == ST_DIV_RUN);
    assign error        = err_reg;

endmodule

// File: tb/tb_calc_core.sv
// Directed and randomized checks of calc_core against an arithmetic
// reference model of the keypad-expression rules.
module tb_calc_core;
    import calc_pkg::*;

    localparam int W = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] operand_in = '0;
    logic         operand_valid = 1'b0;
    logic [4:0]   op_in = '0;
    logic         op_valid = 1'b0;
    logic         overflow_in = 1'b0;
    logic [W-1:0] result;
    logic         result_valid;
    logic         busy;
    logic         error;

    int n_cmp = 0;
    int n_mis = 0;
    int n_txn = 0;

    // reference model: stage 0 idle, 1 have A, 2 have op, 3 have B, 4 error
    int     m_stage;
    longint m_acc, m_b;
    int     m_pend;
    bit     m_err;
    bit     e_pulse, e_chk;
    longint e_val;
    int     e_lat, e_busy;

    always #5 clk = ~clk;

    calc_core #(.WIDTH(W), .DIV_ITER(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .operand_in   (operand_in),
        .operand_valid(operand_valid),
        .op_in        (op_in),
        .op_valid     (op_valid),
        .overflow_in  (overflow_in),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_acc = 0; m_b = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic model_compute(input int nxt);
        longint r;
        bit bad;
        bad = 0;
        r = 0;
        case (m_pend)
            1: r = m_acc + m_b;
            2: r = m_acc - m_b;
            3: r = m_acc * m_b;
            default: begin
                if (m_b == 0) bad = 1;
                else r = m_acc / m_b;
            end
        endcase
        if (r > MAXV || r < MINV) bad = 1;
        e_lat   = (m_pend == 4) ? W + 2 : 2;
        e_busy  = e_lat - 1;
        e_pulse = 1;
        if (bad) begin
            m_err = 1; m_stage = 4; e_val = 0;
        end else begin
            m_acc = r; e_val = r;
            if (nxt == 5) m_stage = 0;
            else begin m_pend = nxt; m_stage = 2; end
        end
    endtask

    task automatic model_apply(input bit is_opnd, input longint v, input int code, input bit ovf);
        e_pulse = 0; e_chk = 1; e_val = 0; e_lat = 0; e_busy = 0;
        if (!is_opnd) begin
            if (ovf || code < 1 || code > 6) return;
            if (code == 6) begin model_reset(); e_pulse = 1; e_val = 0; return; end
        end
        if (m_err) return;
        if (is_opnd) begin
            if (ovf) begin m_err = 1; m_stage = 4; e_chk = 0; return; end
            if (m_stage <= 1) begin m_acc = v; m_stage = 1; end
            else begin m_b = v; m_stage = 3; end
            return;
        end
        if (code == 5) begin
            if (m_stage <= 1) begin e_pulse = 1; e_val = m_acc; m_stage = 0; end
            else if (m_stage == 3) model_compute(code);
        end else begin
            if (m_stage == 3) model_compute(code);
            else begin m_pend = code; m_stage = 2; end
        end
    endtask

    // One strobe, then observe until the core is idle again. inj_k > 0 drives a
    // stray operand at that observation cycle (meant to land while busy).
    task automatic do_strobe(input bit is_opnd, input longint v, input int code,
                             input bit ovf, input string tag, input int inj_k);
        int k, pulses, first_k, busy_cnt;
        longint pv;
        @(negedge clk);
        operand_valid = is_opnd;
        op_valid      = !is_opnd;
        operand_in    = v[W-1:0];
        op_in         = code[4:0];
        overflow_in   = ovf;
        model_apply(is_opnd, v, code, ovf);
        @(negedge clk);
        operand_valid = 0; op_valid = 0; overflow_in = 0;
        k = 1; pulses = 0; first_k = 0; busy_cnt = 0; pv = 0;
        while (1) begin
            if (result_valid) begin
                pulses++;
                if (first_k == 0) begin first_k = k; pv = longint'($signed(result)); end
            end
            if (busy) busy_cnt++;
            if (k >= 2 && !busy) break;
            if (k >= 60) break;
            if (k == inj_k) begin operand_valid = 1; operand_in = 32'd999; end
            @(negedge clk);
            operand_valid = 0;
            k++;
        end
        operand_valid = 0;
        n_txn++;
        $display("txn %0d [%s] %s v=%0d code=%0d ovf=%0d pulses=%0d res=%0d lat=%0d busy=%0d err=%0d",
                 n_txn, tag, is_opnd ? "operand" : "op", v, code, ovf, pulses, pv, first_k,
                 busy_cnt, error);
        check_val({tag, " window_expired"}, longint'(k >= 60), 0);
        if (e_chk) check_val({tag, " pulses"}, pulses, longint'(e_pulse));
        if (e_chk && e_pulse) check_val({tag, " result"}, pv, e_val);
        if (e_lat != 0) begin
            check_val({tag, " latency"}, first_k, e_lat);
            check_val({tag, " busy_cycles"}, busy_cnt, e_busy);
        end else begin
            check_val({tag, " busy_cycles"}, busy_cnt, 0);
        end
        check_val({tag, " error"}, longint'(error), longint'(m_err));
    endtask

    task automatic opnd(input longint v, input string tag);
        do_strobe(1, v, 0, 0, tag, 0);
    endtask

    task automatic opc(input int c, input string tag);
        do_strobe(0, 0, c, 0, tag, 0);
    endtask

    task automatic abort_div_test();
        int pulses;
        opnd(12, "abort"); opc(4, "abort"); opnd(4, "abort");
        @(negedge clk);
        op_valid = 1; op_in = OP_EQ;
        @(negedge clk);
        op_valid = 0;
        // first observation cycle is EXEC; the 10th DIV_RUN cycle is the 11th
        for (int k = 2; k <= 11; k++) @(negedge clk);
        check_val("abort busy_before_reset", longint'(busy), 1);
        rst = 0;
        @(negedge clk);
        rst = 1;
        model_reset();
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (result_valid) pulses++;
            @(negedge clk);
        end
        n_txn++;
        $display("txn %0d [abort] reset during divide, pulses=%0d res=%0d busy=%0d err=%0d",
                 n_txn, pulses, $signed(result), busy, error);
        check_val("abort pulses", pulses, 0);
        check_val("abort result", longint'($signed(result)), 0);
        check_val("abort busy", longint'(busy), 0);
        check_val("abort error", longint'(error), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c;
        longint v;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset result", longint'(result), 0);
        check_val("reset result_valid", longint'(result_valid), 0);
        check_val("reset busy", longint'(busy), 0);
        check_val("reset error", longint'(error), 0);
        rst = 1;

        opnd(12, "add"); opc(1, "add"); opnd(30, "add"); opc(5, "add");
        opc(5, "add_idle_eq");

        opnd(7, "chain"); opc(2, "chain"); opnd(10, "chain"); opc(3, "chain");
        opnd(-3, "chain"); opc(5, "chain");

        opnd(-100, "div"); opc(4, "div"); opnd(7, "div");
        do_strobe(0, 0, 5, 0, "div", 10);
        opc(5, "div_after");

        opnd(5, "dz"); opc(4, "dz"); opnd(0, "dz"); opc(5, "dz");
        opc(1, "dz_ignored"); opc(6, "dz_ac");

        opnd(64'sd2147483647, "addovf"); opc(1, "addovf"); opnd(1, "addovf"); opc(5, "addovf");
        opc(6, "addovf_ac");
        opnd(65536, "mulovf"); opc(3, "mulovf"); opnd(65536, "mulovf"); opc(5, "mulovf");
        opc(6, "mulovf_ac");
        opnd(MINV, "minovf"); opc(4, "minovf"); opnd(-1, "minovf"); opc(5, "minovf");
        opc(6, "minovf_ac");

        do_strobe(1, 3, 0, 1, "kovf", 0);
        opc(6, "kovf_ac");

        opnd(5, "badop"); opc(31, "badop"); opc(0, "badop");
        do_strobe(0, 0, 1, 1, "badop_ovf", 0);
        opc(5, "badop");

        abort_div_test();

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 99);
            if (m_err && r < 50) begin
                opc(6, "rnd");
            end else if (r < 45) begin
                if ($urandom_range(0, 3) == 0) v = longint'(int'($urandom));
                else v = longint'(int'($urandom_range(0, 200)) - 100);
                opnd(v, "rnd");
            end else if (r < 90) begin
                opc($urandom_range(1, 5), "rnd");
            end else if (r < 94) begin
                opc(6, "rnd");
            end else if (r < 97) begin
                c = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(7, 31);
                opc(c, "rnd");
            end else if (r < 98) begin
                do_strobe(1, 1, 0, 1, "rnd_kovf", 0);
            end else begin
                do_strobe(0, 0, $urandom_range(1, 6), 1, "rnd_opovf", 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
